sync_fifo_core: RTL and testbench
=================================

Name: sync_fifo_core

Overview:
- Single-clock, parameterisable-width/depth FIFO core; used as a generic buffer in the switch datapath.
- Write and read ports run in the same clock domain and can operate in the same cycle.
- Exposes empty/full flags and an exact fill level.
- Output is first-word-fall-through (FWFT) or registered-read, selected by parameter.

Parameters:
- P_DATA_WIDTH, 8: data word width in bits.
- P_ADDR_WIDTH, 4: address width; depth DEPTH = 2**P_ADDR_WIDTH entries.
- P_FWFT, 1: 1 = first-word-fall-through output; 0 = registered (one-cycle read latency) output.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- wr_i  input  1  write request; data_i is pushed on the rising edge if accepted.
- data_i  input  P_DATA_WIDTH  write data.
- rd_i  input  1  read request (pop) on the rising edge if accepted.
- data_o  output  P_DATA_WIDTH  read data.
- fill_level_o  output  P_ADDR_WIDTH+1  number of stored entries, 0..DEPTH.
- empty_o  output  1  high when fill level = 0.
- full_o  output  1  high when fill level = DEPTH.

Behaviour:
- Reset (rst_ni=0, asynchronous): write/read pointers = 0, fill_level_o = 0, empty_o = 1, full_o = 0, non-FWFT output register = 0. Storage array is not reset.
- Storage: DEPTH x P_DATA_WIDTH array; write and read pointers are P_ADDR_WIDTH bits and wrap naturally from DEPTH-1 to 0.
- Write accept = wr_i & ~full_o. On accept: mem[wr_ptr] <= data_i; wr_ptr increments.
- Write with full_o=1 is dropped silently: no state change, even if rd_i is high in the same cycle.
- Read accept = rd_i & ~empty_o. On accept: rd_ptr increments.
- Read with empty_o=1 is ignored: no pointer or level change.
- Fill level: +1 on write-only accept, -1 on read-only accept, unchanged when both are accepted or neither.
- empty_o and full_o are registered and derived from the next fill level, so they are valid in the same cycle as fill_level_o.
- FWFT (P_FWFT=1):
  - data_o = mem[rd_ptr] combinationally.
  - The head word is valid whenever empty_o=0.
  - A word written into an empty FIFO appears on data_o in the cycle after the write edge, together with empty_o falling.
  - Asserting rd_i acknowledges the current data_o; the next word appears after the edge.
  - data_o is don't-care while empty_o=1.
- Non-FWFT (P_FWFT=0):
  - On read accept, data_o <= mem[rd_ptr], so the value is valid one cycle after the rd_i edge.
  - data_o holds its value when no read is accepted.
- Simultaneous read and write on an empty FIFO: the read is ignored and the write is accepted; no bypass.
- Simultaneous read and write on a non-empty, non-full FIFO: both are accepted; level unchanged.
- Ordering is strict FIFO: words are read out in exactly the order they were accepted; no loss, duplication or reorder across pointer wrap-around.
- Reset mid-operation discards all contents immediately; flags return to reset values asynchronously.

Optional Feature:
- Macro SYNC_FIFO_CORE_ERR_FLAGS_EN.
- When defined, adds two outputs:
  - overflow_o (1 bit): sticky, set on wr_i & full_o.
  - underflow_o (1 bit): sticky, set on rd_i & empty_o.
- Both flags are cleared only by reset; reset value 0.
- When not defined, the ports and logic are absent and the interface is exactly as listed above.

Test Plan:
- Reset -> empty_o=1, full_o=0, fill_level_o=0; data_o=0 when P_FWFT=0.
- Write 0xA5, then 0x3C on consecutive cycles, no reads (FWFT) -> one cycle after the first write edge empty_o=0 and data_o=0xA5; after both writes fill_level_o=2. Then rd_i for 2 cycles -> data_o 0xA5 then 0x3C; empty_o=1, fill_level_o=0.
- Write 16 words 0x00..0x0F (default parameters), then a 17th word 0xFF with no reads -> full_o=1, fill_level_o=16. Readback yields 0x00..0x0F in order and 0xFF is absent; overflow_o=1 if the macro is enabled.
- Auto-read whenever empty_o=0 while writing 100 random bursts (each 1..free-space words long), then a 100-word continuous burst -> every word is read back in order with zero mismatches; count read = count accepted.
- P_FWFT=0, write 0x11, 0x22, then single-cycle rd_i -> data_o=0x11 one cycle after the rd_i edge and held until the next accepted read, which gives 0x22.
- Read while empty_o=1 -> fill_level_o stays 0, pointers unchanged; underflow_o=1 if the macro is enabled. Asserting rst_ni=0 mid-burst with 5 entries stored -> fill_level_o=0 and empty_o=1 immediately.

Source files
------------

// File: rtl/sync_fifo_core.sv
// sync_fifo_core: single-clock FIFO with FWFT or registered read output; define SYNC_FIFO_CORE_ERR_FLAGS_EN for sticky overflow/underflow flags
module sync_fifo_core #(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_ADDR_WIDTH = 4,
  parameter bit P_FWFT       = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    wr_i,
  input  logic [P_DATA_WIDTH-1:0] data_i,
  input  logic                    rd_i,
  output logic [P_DATA_WIDTH-1:0] data_o,
  output logic [P_ADDR_WIDTH:0]   fill_level_o,
  output logic                    empty_o,
`ifdef SYNC_FIFO_CORE_ERR_FLAGS_EN
  output logic                    full_o,
  output logic                    overflow_o,
  output logic                    underflow_o
`else
  output logic                    full_o
`endif
);
  localparam int L_DEPTH = 2 ** P_ADDR_WIDTH;
  localparam logic [P_ADDR_WIDTH:0] L_FULL_LVL = (P_ADDR_WIDTH + 1)'(L_DEPTH);
  localparam logic [P_ADDR_WIDTH:0] L_LVL_ONE = (P_ADDR_WIDTH + 1)'(1);
  localparam logic [P_ADDR_WIDTH-1:0] L_PTR_ONE = P_ADDR_WIDTH'(1);
  logic [P_DATA_WIDTH-1:0] r_mem [L_DEPTH];
  logic [P_ADDR_WIDTH-1:0] r_wr_ptr;
  logic [P_ADDR_WIDTH-1:0] r_rd_ptr;
  logic [P_ADDR_WIDTH:0]   r_level;
  logic                    r_empty;
  logic                    r_full;
  logic                    w_wr_acc;
  logic                    w_rd_acc;
  logic [P_ADDR_WIDTH:0]   w_level_nxt;
  assign w_wr_acc     = wr_i & ~r_full;
  assign w_rd_acc     = rd_i & ~r_empty;
  assign fill_level_o = r_level;
  assign empty_o      = r_empty;
  assign full_o       = r_full;
  // Next fill level: a simultaneous push and pop cancel out
  always_comb begin
    w_level_nxt = (w_wr_acc & ~w_rd_acc) ? r_level + L_LVL_ONE :
                  (w_rd_acc & ~w_wr_acc) ? r_level - L_LVL_ONE : r_level;
  end
  // Pointers, level and flags; flags come from the next level so they line up with fill_level_o
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + L_PTR_ONE;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + L_PTR_ONE;
      r_level <= w_level_nxt;
      r_empty <= (w_level_nxt == '0);
      r_full  <= (w_level_nxt == L_FULL_LVL);
    end
  end
  // Storage is deliberately not reset so it maps onto plain RAM
  always_ff @(posedge clk_i) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= data_i;
  end
  if (P_FWFT) begin : g_fwft
    assign data_o = r_mem[r_rd_ptr];
  end else begin : g_reg
    logic [P_DATA_WIDTH-1:0] r_data;
    // Registered read: head word captured on an accepted pop, held otherwise
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_data <= '0;
      else if (w_rd_acc) r_data <= r_mem[r_rd_ptr];
    end
    assign data_o = r_data;
  end
`ifdef SYNC_FIFO_CORE_ERR_FLAGS_EN
  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (wr_i & r_full) overflow_o <= 1'b1;
      if (rd_i & r_empty) underflow_o <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_sync_fifo_core.sv
// tb_sync_fifo_core: scoreboard bench for sync_fifo_core (FWFT and registered-read instances)
module tb_sync_fifo_core;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr = 1'b0, rd = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic [4:0] lvl;
  logic       emp, ful;
  logic       wr2 = 1'b0, rd2 = 1'b0;
  logic [7:0] din2 = '0;
  logic [7:0] dout2;
  logic [4:0] lvl2;
  logic       emp2, ful2;
`ifdef SYNC_FIFO_CORE_ERR_FLAGS_EN
  logic ovf, udf, ovf2, udf2;
`endif
  int vec = 0;
  int miss = 0;
  logic [7:0] q[$];
  always #5 clk = ~clk;
  sync_fifo_core #(.P_DATA_WIDTH(8), .P_ADDR_WIDTH(4), .P_FWFT(1'b1)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .wr_i(wr), .data_i(din), .rd_i(rd),
    .data_o(dout), .fill_level_o(lvl), .empty_o(emp),
`ifdef SYNC_FIFO_CORE_ERR_FLAGS_EN
    .full_o(ful), .overflow_o(ovf), .underflow_o(udf)
`else
    .full_o(ful)
`endif
  );
  sync_fifo_core #(.P_DATA_WIDTH(8), .P_ADDR_WIDTH(4), .P_FWFT(1'b0)) u_reg (
    .clk_i(clk), .rst_ni(rst_n), .wr_i(wr2), .data_i(din2), .rd_i(rd2),
    .data_o(dout2), .fill_level_o(lvl2), .empty_o(emp2),
`ifdef SYNC_FIFO_CORE_ERR_FLAGS_EN
    .full_o(ful2), .overflow_o(ovf2), .underflow_o(udf2)
`else
    .full_o(ful2)
`endif
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    vec++; if (emp !== 1'b1) begin miss++; $display("FAIL reset_empty: got %b want 1", emp); end
    vec++; if (ful !== 1'b0) begin miss++; $display("FAIL reset_full: got %b want 0", ful); end
    vec++; if (lvl !== 5'd0) begin miss++; $display("FAIL reset_level: got %0d want 0", lvl); end
    vec++; if (dout2 !== 8'h00) begin miss++; $display("FAIL reset_reg_data: got %h want 00", dout2); end
    vec++; if (emp2 !== 1'b1) begin miss++; $display("FAIL reset_reg_empty: got %b want 1", emp2); end
`ifdef SYNC_FIFO_CORE_ERR_FLAGS_EN
    vec++; if (ovf !== 1'b0 || udf !== 1'b0) begin miss++; $display("FAIL reset_errflags: got %b%b want 00", ovf, udf); end
`endif
    rst_n = 1'b1;
    tick();
  endtask
  task automatic test_basic();
    wr = 1'b1; din = 8'hA5;
    tick();
    vec++; if (emp !== 1'b0) begin miss++; $display("FAIL basic_empty_fall: got %b want 0", emp); end
    vec++; if (dout !== 8'hA5) begin miss++; $display("FAIL basic_head: got %h want a5", dout); end
    din = 8'h3C;
    tick();
    wr = 1'b0;
    vec++; if (lvl !== 5'd2) begin miss++; $display("FAIL basic_level2: got %0d want 2", lvl); end
    rd = 1'b1;
    vec++; if (dout !== 8'hA5) begin miss++; $display("FAIL basic_rd0: got %h want a5", dout); end
    tick();
    vec++; if (dout !== 8'h3C) begin miss++; $display("FAIL basic_rd1: got %h want 3c", dout); end
    tick();
    rd = 1'b0;
    vec++; if (emp !== 1'b1 || lvl !== 5'd0) begin miss++; $display("FAIL basic_drained: got empty=%b lvl=%0d want 1/0", emp, lvl); end
  endtask
  task automatic test_full();
    for (int i = 0; i < 16; i++) begin
      wr = 1'b1; din = 8'(i);
      tick();
    end
    din = 8'hFF;
    tick();
    wr = 1'b0;
    vec++; if (ful !== 1'b1 || lvl !== 5'd16) begin miss++; $display("FAIL full_flag: got full=%b lvl=%0d want 1/16", ful, lvl); end
`ifdef SYNC_FIFO_CORE_ERR_FLAGS_EN
    vec++; if (ovf !== 1'b1) begin miss++; $display("FAIL full_overflow: got %b want 1", ovf); end
`endif
    rd = 1'b1;
    for (int i = 0; i < 16; i++) begin
      vec++; if (dout !== 8'(i)) begin miss++; $display("FAIL full_readback[%0d]: got %h want %h", i, dout, 8'(i)); end
      tick();
    end
    rd = 1'b0;
    vec++; if (emp !== 1'b1 || lvl !== 5'd0) begin miss++; $display("FAIL full_no_ff: got empty=%b lvl=%0d want 1/0", emp, lvl); end
  endtask
  task automatic test_random();
    int mlvl = 0;
    int nwr = 0;
    int nrd = 0;
    int bad = 0;
    q.delete();
    for (int b = 0; b < 101; b++) begin
      int len = (b == 100) ? 100 : $urandom_range(1, 16 - mlvl);
      for (int k = 0; k < len + 1; k++) begin
        logic wacc, racc;
        wr = (k < len); din = 8'($urandom);
        rd = !emp;
        wacc = wr && mlvl < 16;
        racc = rd && mlvl > 0;
        if (racc) begin
          vec++;
          if (q.size() == 0 || dout !== q[0]) begin miss++; bad++; $display("FAIL rand_order: got %h want %h", dout, q.size() ? q[0] : 8'hxx); end
          if (q.size() != 0) void'(q.pop_front());
          nrd++;
        end
        if (wacc) begin q.push_back(din); nwr++; end
        mlvl = mlvl + int'(wacc) - int'(racc);
        tick();
        if (lvl !== 5'(mlvl)) begin vec++; miss++; bad++; $display("FAIL rand_level: got %0d want %0d", lvl, mlvl); end
      end
    end
    wr = 1'b0;
    for (int t = 0; t < 40 && mlvl > 0; t++) begin
      rd = 1'b1;
      vec++; if (dout !== q[0]) begin miss++; $display("FAIL rand_drain: got %h want %h", dout, q[0]); end
      void'(q.pop_front());
      nrd++;
      mlvl--;
      tick();
    end
    rd = 1'b0;
    vec++; if (nrd != nwr || q.size() != 0 || emp !== 1'b1) begin miss++; $display("FAIL rand_count: got read=%0d left=%0d want read=%0d left=0", nrd, q.size(), nwr); end
  endtask
  task automatic test_nonfwft();
    wr2 = 1'b1; din2 = 8'h11;
    tick();
    din2 = 8'h22;
    tick();
    wr2 = 1'b0;
    vec++; if (dout2 !== 8'h00) begin miss++; $display("FAIL reg_no_read: got %h want 00", dout2); end
    rd2 = 1'b1;
    tick();
    rd2 = 1'b0;
    vec++; if (dout2 !== 8'h11 || lvl2 !== 5'd1) begin miss++; $display("FAIL reg_first: got %h lvl=%0d want 11/1", dout2, lvl2); end
    tick();
    tick();
    vec++; if (dout2 !== 8'h11) begin miss++; $display("FAIL reg_hold: got %h want 11", dout2); end
    rd2 = 1'b1;
    tick();
    rd2 = 1'b0;
    vec++; if (dout2 !== 8'h22 || emp2 !== 1'b1) begin miss++; $display("FAIL reg_second: got %h empty=%b want 22/1", dout2, emp2); end
    rd2 = 1'b1;
    tick();
    rd2 = 1'b0;
    vec++; if (dout2 !== 8'h22 || lvl2 !== 5'd0) begin miss++; $display("FAIL reg_empty_read: got %h lvl=%0d want 22/0", dout2, lvl2); end
  endtask
  task automatic test_underflow();
    rd = 1'b1;
    tick();
    tick();
    rd = 1'b0;
    vec++; if (lvl !== 5'd0 || emp !== 1'b1 || ful !== 1'b0) begin miss++; $display("FAIL under_level: got lvl=%0d empty=%b full=%b want 0/1/0", lvl, emp, ful); end
`ifdef SYNC_FIFO_CORE_ERR_FLAGS_EN
    vec++; if (udf !== 1'b1) begin miss++; $display("FAIL under_flag: got %b want 1", udf); end
`endif
    wr = 1'b1; rd = 1'b1; din = 8'h5A;
    tick();
    wr = 1'b0; rd = 1'b0;
    vec++; if (dout !== 8'h5A || lvl !== 5'd1) begin miss++; $display("FAIL under_ptr: got %h lvl=%0d want 5a/1", dout, lvl); end
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask
  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      wr = 1'b1; din = 8'(8'h40 + i);
      tick();
    end
    vec++; if (lvl !== 5'd5) begin miss++; $display("FAIL mid_level5: got %0d want 5", lvl); end
    rst_n = 1'b0;
    #1;
    vec++; if (lvl !== 5'd0 || emp !== 1'b1) begin miss++; $display("FAIL mid_async: got lvl=%0d empty=%b want 0/1", lvl, emp); end
`ifdef SYNC_FIFO_CORE_ERR_FLAGS_EN
    vec++; if (ovf !== 1'b0 || udf !== 1'b0) begin miss++; $display("FAIL mid_errflags: got %b%b want 00", ovf, udf); end
`endif
    wr = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    vec++; if (emp !== 1'b1 || lvl !== 5'd0) begin miss++; $display("FAIL mid_after: got empty=%b lvl=%0d want 1/0", emp, lvl); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_full();
    test_random();
    test_nonfwft();
    test_underflow();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
